// File: rtl/audio_pkg.sv
// audio_pkg: shared types, cfg field codes and tick divider helper for the playback sequencer.
package audio_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, PAUSE} state_e;

    localparam logic CFG_START = 1'b0;
    localparam logic CFG_END   = 1'b1;

    function automatic int calc_div(input int clock_rate, input int sample_rate);
        return clock_rate / sample_rate;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: sample-rate divider; counts while run_i, pulses tick_o on the last count and wraps.
module sample_tick_gen #(
    parameter int DIV = 195
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == CW'(DIV - 1));

    always_comb cnt_d = clear_i ? '0 : !run_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl: clip-table playback sequencer; fetches samples over req/ack
// and hands one sample per sample-rate tick to the PWM stage.
module audio_playback_ctrl
    import audio_pkg::*;
#(
    parameter int CLOCK_RATE  = 3125000,
    parameter int SAMPLE_RATE = 16000,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int NUM_CLIPS   = 4,
    parameter int CLIP_W      = $clog2(NUM_CLIPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              cmd_pause,
    input  logic [CLIP_W-1:0] clip_sel,
    input  logic              loop_en,
    input  logic              cfg_we,
    input  logic [CLIP_W-1:0] cfg_clip,
    input  logic              cfg_field,
    input  logic [ADDR_W-1:0] cfg_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              smp_valid,
    output logic [DATA_W-1:0] smp_data,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic              underrun
);

    localparam int DIV = calc_div(CLOCK_RATE, SAMPLE_RATE);

    if (DIV < 2) begin : g_div_check
        $error("audio_playback_ctrl: CLOCK_RATE/SAMPLE_RATE must give a divider of at least 2");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] start_tab_q [NUM_CLIPS];
    logic [ADDR_W-1:0] end_tab_q   [NUM_CLIPS];
    logic [ADDR_W-1:0] start_q, start_d, end_q, end_d, addr_q, addr_d;
    logic [DATA_W-1:0] buf_q, buf_d, smp_data_q, smp_data_d;
    logic              smp_valid_q, smp_valid_d, done_q, done_d;
    logic              underrun_q, underrun_d, pend_q, pend_d;
    logic              stop, play, tick, last, finish;

    assign stop   = cmd_stop || !enable;
    assign play   = !stop && cmd_play;
    assign last   = addr_q == end_q;
    assign finish = last && !loop_en;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (state_q == FETCH || state_q == PLAY),
        .clear_i(play),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_tab_q <= '{default: '0};
            end_tab_q   <= '{default: '0};
        end else if (cfg_we) begin
            if (cfg_field == CFG_START) start_tab_q[cfg_clip] <= cfg_data;
            else                        end_tab_q[cfg_clip]   <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= '0;
            end_q       <= '0;
            addr_q      <= '0;
            buf_q       <= '0;
            smp_data_q  <= '0;
            smp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            smp_data_q  <= smp_data_d;
            smp_valid_q <= smp_valid_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            pend_q      <= pend_d;
        end
    end

    // A pause seen while fetching (or on the tick that starts a fetch) waits in pend_q for the ack.
    always_comb begin
        state_d = state_q;
        if (stop) state_d = IDLE;
        else if (play) state_d = FETCH;
        else begin
            case (state_q)
                FETCH:   if (mem_ack) state_d = (pend_q ^ cmd_pause) ? PAUSE : PLAY;
                PLAY:    if (tick) state_d = finish ? IDLE : FETCH;
                         else if (cmd_pause) state_d = PAUSE;
                PAUSE:   if (cmd_pause) state_d = PLAY;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        start_d     = start_q;
        end_d       = end_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        smp_data_d  = smp_data_q;
        smp_valid_d = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        pend_d      = pend_q;
        if (play) begin
            start_d    = start_tab_q[clip_sel];
            end_d      = end_tab_q[clip_sel];
            addr_d     = start_tab_q[clip_sel];
            underrun_d = 1'b0;
            pend_d     = 1'b0;
        end else if (!stop && state_q == FETCH) begin
            underrun_d = underrun_q || tick;
            buf_d      = mem_ack ? mem_data : buf_q;
            pend_d     = mem_ack ? 1'b0 : pend_q ^ cmd_pause;
        end else if (!stop && state_q == PLAY && tick) begin
            smp_valid_d = 1'b1;
            smp_data_d  = buf_q;
            done_d      = finish;
            addr_d      = last ? start_q : addr_q + 1'b1;
            pend_d      = cmd_pause && !finish;
        end
    end

    always_comb begin
        mem_req   = state_q == FETCH;
        busy      = state_q != IDLE;
        paused    = state_q == PAUSE;
        mem_addr  = addr_q;
        smp_valid = smp_valid_q;
        smp_data  = smp_data_q;
        done      = done_q;
        underrun  = underrun_q;
    end

endmodule
